// File: rtl/nfu_pkg.sv
// Shared definitions for the nonlinear-function-unit dispatcher and controller.
//   nfu_mode_e  : job mode encoding seen on cmd_mode / nfu_mode
//   nfu_state_e : one-hot dispatcher FSM states
package nfu_pkg;

  typedef enum logic [1:0] {
    MODE_SOFTMAX = 2'b00,
    MODE_GELU    = 2'b01,
    MODE_SILU    = 2'b10,
    MODE_ROOT    = 2'b11
  } nfu_mode_e;

  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StLoad  = 5'b00010,
    StStart = 5'b00100,
    StWait  = 5'b01000,
    StDrain = 5'b10000
  } nfu_state_e;

endpackage

// File: rtl/nfu_dispatcher_if.sv
// Host / controller signal bundle of the dispatcher.
//   cmd_*   : job request from host (valid/ready)
//   in_*    : host sample stream into the operand buffer
//   nfu_*   : start pulse, mode, operands, completion and results of the NFU controller
//   out_*   : result stream back to host (valid/ready, last marks final sample)
//   busy, err_timeout : status
// Modport slave is the dispatcher view; master is the host/controller view.
interface nfu_dispatcher_if #(
  parameter int unsigned DATA_NUM        = 16,
  parameter int unsigned FIX_POINT_WIDTH = 16
) ();

  logic                                  cmd_valid;
  logic [1:0]                            cmd_mode;
  logic                                  cmd_ready;
  logic                                  in_valid;
  logic [FIX_POINT_WIDTH-1:0]            in_data;
  logic                                  in_ready;
  logic                                  nfu_en;
  logic [1:0]                            nfu_mode;
  logic [DATA_NUM*FIX_POINT_WIDTH-1:0]   nfu_op;
  logic                                  nfu_finish;
  logic [DATA_NUM*FIX_POINT_WIDTH-1:0]   nfu_res;
  logic                                  out_valid;
  logic [FIX_POINT_WIDTH-1:0]            out_data;
  logic                                  out_last;
  logic                                  out_ready;
  logic                                  busy;
  logic                                  err_timeout;

  modport slave (
    input  cmd_valid, cmd_mode, in_valid, in_data, nfu_finish, nfu_res, out_ready,
    output cmd_ready, in_ready, nfu_en, nfu_mode, nfu_op, out_valid, out_data, out_last,
           busy, err_timeout
  );

  modport master (
    output cmd_valid, cmd_mode, in_valid, in_data, nfu_finish, nfu_res, out_ready,
    input  cmd_ready, in_ready, nfu_en, nfu_mode, nfu_op, out_valid, out_data, out_last,
           busy, err_timeout
  );

endinterface

// File: rtl/nfu_sample_buf.sv
// DATA_NUM x FIX_POINT_WIDTH sample register array.
//   we_i/waddr_i/wdata_i : single-sample write
//   ld_i/ld_data_i       : whole-array load from a flat bus (wins over we_i)
//   rdata_o              : flat read bus, sample i at [i*W +: W]
// Contents are not reset; they are always written before being consumed.
module nfu_sample_buf #(
  parameter int unsigned DATA_NUM        = 16,
  parameter int unsigned FIX_POINT_WIDTH = 16
) (
  input  logic                                clk_i,
  input  logic                                we_i,
  input  logic [$clog2(DATA_NUM)-1:0]         waddr_i,
  input  logic [FIX_POINT_WIDTH-1:0]          wdata_i,
  input  logic                                ld_i,
  input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] ld_data_i,
  output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] rdata_o
);

  logic [FIX_POINT_WIDTH-1:0] mem_q [DATA_NUM];

  always_ff @(posedge clk_i) begin
    if (ld_i) begin
      for (int unsigned i = 0; i < DATA_NUM; i++) begin
        mem_q[i] <= ld_data_i[i*FIX_POINT_WIDTH +: FIX_POINT_WIDTH];
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < DATA_NUM; i++) begin
      rdata_o[i*FIX_POINT_WIDTH +: FIX_POINT_WIDTH] = mem_q[i];
    end
  end

endmodule

// File: rtl/nfu_dispatcher.sv
// Job dispatcher for the nonlinear function unit.
// Accepts a job (mode), collects DATA_NUM samples into the operand buffer, pulses nfu_en,
// waits up to TIMEOUT cycles for nfu_finish, captures the result vector and streams it out.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : nfu_dispatcher_if slave modport (all handshake, data and status signals)
module nfu_dispatcher
  import nfu_pkg::*;
#(
  parameter int unsigned DATA_NUM        = 16,
  parameter int unsigned FIX_POINT_WIDTH = 16,
  parameter int unsigned TIMEOUT         = 1024
) (
  input logic              clk,
  input logic              rst_n,
  nfu_dispatcher_if.slave  bus
);

  localparam int unsigned IdxW  = $clog2(DATA_NUM);
  localparam int unsigned CntW  = IdxW + 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT) + 1;
  localparam int unsigned BusW  = DATA_NUM * FIX_POINT_WIDTH;

  localparam logic [CntW-1:0]  LastIdx  = CntW'(DATA_NUM - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  nfu_state_e       state_q, state_d;
  nfu_mode_e        mode_q, mode_d;
  logic [CntW-1:0]  load_cnt_q, load_cnt_d;
  logic [CntW-1:0]  drain_cnt_q, drain_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  logic             op_we, res_ld;
  logic [BusW-1:0]  op_bus, res_bus;

  nfu_sample_buf #(
    .DATA_NUM       (DATA_NUM),
    .FIX_POINT_WIDTH(FIX_POINT_WIDTH)
  ) u_op_buf (
    .clk_i    (clk),
    .we_i     (op_we),
    .waddr_i  (load_cnt_q[IdxW-1:0]),
    .wdata_i  (bus.in_data),
    .ld_i     (1'b0),
    .ld_data_i({BusW{1'b0}}),
    .rdata_o  (op_bus)
  );

  nfu_sample_buf #(
    .DATA_NUM       (DATA_NUM),
    .FIX_POINT_WIDTH(FIX_POINT_WIDTH)
  ) u_res_buf (
    .clk_i    (clk),
    .we_i     (1'b0),
    .waddr_i  ({IdxW{1'b0}}),
    .wdata_i  ({FIX_POINT_WIDTH{1'b0}}),
    .ld_i     (res_ld),
    .ld_data_i(bus.nfu_res),
    .rdata_o  (res_bus)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= MODE_SOFTMAX;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      load_cnt_q  <= load_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    op_we       = 1'b0;
    res_ld      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          mode_d     = nfu_mode_e'(bus.cmd_mode);
          err_d      = 1'b0;
          load_cnt_d = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          op_we      = 1'b1;
          load_cnt_d = load_cnt_q + CntW'(1);
          if (load_cnt_q == LastIdx) state_d = StStart;
        end
      end
      StStart: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        // A finish arriving on the timeout cycle still counts as a completed job.
        if (bus.nfu_finish) begin
          res_ld      = 1'b1;
          drain_cnt_d = '0;
          state_d     = StDrain;
        end else if (wait_cnt_q == WaitLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StDrain: begin
        if (bus.out_ready) begin
          drain_cnt_d = drain_cnt_q + CntW'(1);
          if (drain_cnt_q == LastIdx) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.cmd_ready   = (state_q == StIdle);
  assign bus.in_ready    = (state_q == StLoad);
  assign bus.nfu_en      = (state_q == StStart);
  assign bus.nfu_mode    = ((state_q == StStart) || (state_q == StWait)) ? mode_q : MODE_SOFTMAX;
  assign bus.nfu_op      = op_bus;
  assign bus.out_valid   = (state_q == StDrain);
  assign bus.out_data    = res_bus[drain_cnt_q[IdxW-1:0]*FIX_POINT_WIDTH +: FIX_POINT_WIDTH];
  assign bus.out_last    = (state_q == StDrain) && (drain_cnt_q == LastIdx);
  assign bus.busy        = (state_q != StIdle);
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_nfu_dispatcher.sv
// Directed bench: two dispatchers share stimulus, u_dut_a with TIMEOUT=1024 and u_dut_b with
// TIMEOUT=8, so the same job sequence exercises both normal completion and timeout paths.
module tb_nfu_dispatcher;
  import nfu_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned W  = 16;
  localparam int unsigned BW = N * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_mode = 2'b00;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          nfu_finish = 1'b0;
  logic [BW-1:0] nfu_res = '0;
  logic          out_ready = 1'b0;

  nfu_dispatcher_if #(.DATA_NUM(N), .FIX_POINT_WIDTH(W)) ifa ();
  nfu_dispatcher_if #(.DATA_NUM(N), .FIX_POINT_WIDTH(W)) ifb ();

  assign ifa.cmd_valid = cmd_valid;   assign ifb.cmd_valid = cmd_valid;
  assign ifa.cmd_mode = cmd_mode;     assign ifb.cmd_mode = cmd_mode;
  assign ifa.in_valid = in_valid;     assign ifb.in_valid = in_valid;
  assign ifa.in_data = in_data;       assign ifb.in_data = in_data;
  assign ifa.nfu_finish = nfu_finish; assign ifb.nfu_finish = nfu_finish;
  assign ifa.nfu_res = nfu_res;       assign ifb.nfu_res = nfu_res;
  assign ifa.out_ready = out_ready;   assign ifb.out_ready = out_ready;

  nfu_dispatcher #(.DATA_NUM(N), .FIX_POINT_WIDTH(W), .TIMEOUT(1024)) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  nfu_dispatcher #(.DATA_NUM(N), .FIX_POINT_WIDTH(W), .TIMEOUT(8)) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  // Result-stream observation from the selected instance.
  logic         sel = 1'b0;
  logic         out_valid_s, out_last_s, busy_s;
  logic [W-1:0] out_data_s;
  assign out_valid_s = sel ? ifb.out_valid : ifa.out_valid;
  assign out_last_s  = sel ? ifb.out_last  : ifa.out_last;
  assign out_data_s  = sel ? ifb.out_data  : ifa.out_data;
  assign busy_s      = sel ? ifb.busy      : ifa.busy;

  int unsigned en_a = 0;
  int unsigned en_b = 0;
  always @(posedge clk) begin
    if (ifa.nfu_en) en_a <= en_a + 1;
    if (ifb.nfu_en) en_b <= en_b + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] mkvec(input logic [W-1:0] base, input logic [W-1:0] stp);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = base + stp * W'(i);
    return v;
  endfunction

  // Issue a command and load N samples; returns in the START cycle.
  task automatic do_load(input logic [1:0] mode, input logic [BW-1:0] v, input bit toggle);
    int beat;
    int cyc;
    beat = 0;
    cyc  = 0;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    chk("cmd_ready", ifa.cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("err_clear_a", ifa.err_timeout, 0);
    chk("err_clear_b", ifb.err_timeout, 0);
    chk("load_busy", ifa.busy, 1);
    while (beat < N && cyc < 4 * N) begin
      if (toggle && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = v[beat*W +: W];
        chk("in_ready", ifa.in_ready, 1);
        beat++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("en_latency_a", ifa.nfu_en, 1);
    chk("en_latency_b", ifb.nfu_en, 1);
    chk("op_buf", ifa.nfu_op, v);
  endtask

  // From START, spend n WAIT cycles, assert finish on the n-th; returns in first DRAIN cycle.
  task automatic run_wait(input int n, input logic [1:0] mode, input logic [BW-1:0] op,
                          input logic [BW-1:0] res);
    bit hold_ok;
    int unsigned e0;
    hold_ok = 1'b1;
    e0 = en_a;
    if (ifa.nfu_mode !== mode) hold_ok = 1'b0;
    for (int c = 1; c <= n; c++) begin
      step();
      if (ifa.nfu_mode !== mode || ifa.nfu_en !== 1'b0) hold_ok = 1'b0;
    end
    chk("op_hold", ifa.nfu_op, op);
    nfu_finish = 1'b1;
    nfu_res    = res;
    step();
    nfu_finish = 1'b0;
    chk("mode_hold", hold_ok, 1);
    chk("en_once", en_a - e0, 1);
    chk("drain_latency", out_valid_s, 1);
    chk("mode_idle", ifa.nfu_mode, 0);
  endtask

  task automatic drain(input logic [BW-1:0] exp, input bit bp);
    int k;
    int cyc;
    bit stalled;
    logic [W-1:0] held;
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (k < N && cyc < 4 * N) begin
      out_ready = !(bp && (cyc % 2 == 1));
      chk("out_valid", out_valid_s, 1);
      if (stalled) chk("stall_hold", out_data_s, held);
      if (out_ready) begin
        chk("out_data", out_data_s, exp[k*W +: W]);
        chk("out_last", out_last_s, (k == N - 1));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = out_data_s;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_end_valid", out_valid_s, 0);
    chk("drain_end_busy", busy_s, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] va, vt, vr, vb, vbr, vq, vqr;
    int n;
    bit ov;
    int unsigned ea, eb;

    // Reset state, observed while rst_n is still low.
    #12;
    chk("rst_busy_a", ifa.busy, 0);
    chk("rst_err_a", ifa.err_timeout, 0);
    chk("rst_en_a", ifa.nfu_en, 0);
    chk("rst_valid_a", ifa.out_valid, 0);
    chk("rst_mode_a", ifa.nfu_mode, 0);
    chk("rst_cmd_ready_a", ifa.cmd_ready, 1);
    chk("rst_busy_b", ifb.busy, 0);
    chk("rst_err_b", ifb.err_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Softmax: samples 1..16, finish after 40 cycles, res = op. B times out meanwhile.
    va = mkvec(16'h0001, 16'h0001);
    do_load(MODE_SOFTMAX, va, 1'b0);
    run_wait(40, MODE_SOFTMAX, va, va);
    chk("b_err_in_softmax", ifb.err_timeout, 1);
    chk("a_err_softmax", ifa.err_timeout, 0);
    drain(va, 1'b0);

    // Timeout on B: 8 WAIT cycles then IDLE with err, never out_valid. A keeps waiting.
    vt = mkvec(16'h0A00, 16'h0003);
    do_load(MODE_SILU, vt, 1'b0);
    n  = 0;
    ov = 1'b0;
    step();
    while (ifb.busy && n < 50) begin
      if (ifb.out_valid) ov = 1'b1;
      n++;
      step();
    end
    chk("to_cycles", n, 8);
    chk("to_err", ifb.err_timeout, 1);
    chk("to_no_out", ov, 0);
    chk("to_a_busy", ifa.busy, 1);
    chk("to_a_err", ifa.err_timeout, 0);

    // Finish lands while B is idle: B ignores it, A drains.
    vr = mkvec(16'hF000, 16'h0001);
    nfu_finish = 1'b1;
    nfu_res    = vr;
    step();
    nfu_finish = 1'b0;
    chk("ign_b_valid", ifb.out_valid, 0);
    chk("ign_b_busy", ifb.busy, 0);
    drain(vr, 1'b0);
    chk("sticky_err", ifb.err_timeout, 1);

    // Boundary on B: finish exactly on its timeout cycle, with 50% in/out backpressure.
    vb  = mkvec(16'h0011, 16'h0101);
    vbr = mkvec(16'hB000, 16'h0010);
    do_load(MODE_GELU, vb, 1'b1);
    sel = 1'b1;
    run_wait(8, MODE_GELU, vb, vbr);
    chk("bnd_err", ifb.err_timeout, 0);
    drain(vbr, 1'b1);
    sel = 1'b0;

    // Root: finish after 6 cycles.
    vq  = mkvec(16'h2000, 16'h0001);
    vqr = mkvec(16'h8000, 16'h0003);
    do_load(MODE_ROOT, vq, 1'b0);
    run_wait(6, MODE_ROOT, vq, vqr);
    drain(vqr, 1'b0);

    // Reset in the middle of WAIT; a late finish must be ignored.
    do_load(MODE_GELU, vq, 1'b0);
    step();
    step();
    step();
    chk("pre_rst_busy", ifa.busy, 1);
    chk("pre_rst_mode", ifa.nfu_mode, 2'b01);
    ea = en_a;
    eb = en_b;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy_a", ifa.busy, 0);
    chk("mid_rst_mode_a", ifa.nfu_mode, 0);
    chk("mid_rst_en_a", ifa.nfu_en, 0);
    chk("mid_rst_valid_a", ifa.out_valid, 0);
    chk("mid_rst_in_ready_a", ifa.in_ready, 0);
    chk("mid_rst_busy_b", ifb.busy, 0);
    chk("mid_rst_mode_b", ifb.nfu_mode, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nfu_finish = 1'b1;
    nfu_res    = vqr;
    step();
    nfu_finish = 1'b0;
    ov = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ifa.out_valid || ifb.out_valid || ifa.busy || ifb.busy) ov = 1'b1;
      step();
    end
    chk("late_finish_ignored", ov, 0);
    chk("no_en_after_rst_a", en_a - ea, 0);
    chk("no_en_after_rst_b", en_b - eb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
